// File: rtl/timer_slot_arbiter.sv
// Shared cycle-delay counter: round-robin grant among NUM_REQ requesters,
// run the granted delay, then pulse the owner's done line for one cycle.
module timer_slot_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int CNT_WIDTH = 8,
  parameter int ID_WIDTH  = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*CNT_WIDTH-1:0] req_count,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         abort,
  output logic [NUM_REQ-1:0]           done,
  output logic                         busy,
  output logic [ID_WIDTH-1:0]          active_id,
  output logic [CNT_WIDTH-1:0]         remaining
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                r_state, w_next;
  logic [ID_WIDTH-1:0]   r_id, r_ptr, w_win;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  w_found;

  // Scan upward from r_ptr with wrap; first valid requester wins.
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_win   = '0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(r_ptr) + k) % NUM_REQ;
      if (!w_found && req_valid[idx]) begin
        w_found = 1'b1;
        w_win   = ID_WIDTH'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (r_state == S_IDLE && !reset && w_found) req_ready[w_win] = 1'b1;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_next = S_RUN;
      S_RUN:   if (abort) w_next = S_IDLE;
               else if (r_cnt == '0) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_id    <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (w_found) begin
          r_cnt <= req_count[int'(w_win)*CNT_WIDTH +: CNT_WIDTH];
          r_id  <= w_win;
          r_ptr <= (int'(w_win) == NUM_REQ-1) ? '0 : w_win + ID_WIDTH'(1);
        end
        S_RUN: begin
          if (abort)               r_cnt <= '0;
          else if (r_cnt != '0)    r_cnt <= r_cnt - CNT_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  // Gating with reset drops a pulse that would otherwise show in the reset cycle.
  always_comb begin
    done = '0;
    if (r_state == S_DONE && !reset) done[r_id] = 1'b1;
  end

  assign busy      = (r_state != S_IDLE);
  assign active_id = r_id;
  assign remaining = r_cnt;

endmodule

// File: tb/tb_timer_slot_arbiter.sv
// Directed bench for timer_slot_arbiter: grant timing, round-robin order,
// abort, reset mid-run and the maximum delay count.
module tb_timer_slot_arbiter;
  localparam int NR = 4, CW = 8, IW = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [NR-1:0]  req_valid;
  logic [NR*CW-1:0] req_count;
  logic [NR-1:0]  req_ready;
  logic           abort;
  logic [NR-1:0]  done;
  logic           busy;
  logic [IW-1:0]  active_id;
  logic [CW-1:0]  remaining;

  int checks = 0, failures = 0;

  timer_slot_arbiter #(.NUM_REQ(NR), .CNT_WIDTH(CW), .ID_WIDTH(IW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_count(req_count),
    .req_ready(req_ready), .abort(abort), .done(done), .busy(busy),
    .active_id(active_id), .remaining(remaining)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_count(input int i, input int c);
    req_count[i*CW +: CW] = CW'(c);
  endtask

  task automatic test_reset();
    req_valid = 4'hF;
    tick(); tick(); tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (remaining !== 8'd0) begin failures++; $display("FAIL rst_rem got=%0d exp=0", remaining); end
    checks++; if (active_id !== 2'd0) begin failures++; $display("FAIL rst_id got=%0d exp=0", active_id); end
    checks++; if (done !== 4'b0) begin failures++; $display("FAIL rst_done got=%b exp=0000", done); end
    checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0000", req_ready); end
    req_valid = '0; reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    set_count(0, 7); req_valid = 4'b0001; #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_ready got=%b exp=0001", req_ready); end
    tick(); req_valid = '0;
    for (int k = 0; k < 8; k++) begin
      checks++; if (busy !== 1'b1 || remaining !== CW'(7-k) || done !== 4'b0 || active_id !== 2'd0) begin
        failures++; $display("FAIL single_run k=%0d busy=%b rem=%0d done=%b id=%0d exp busy=1 rem=%0d done=0000 id=0",
                             k, busy, remaining, done, active_id, 7-k);
      end
      tick();
    end
    checks++; if (done !== 4'b0001 || busy !== 1'b1) begin failures++; $display("FAIL single_done got done=%b busy=%b exp 0001/1", done, busy); end
    tick();
    checks++; if (busy !== 1'b0 || done !== 4'b0) begin failures++; $display("FAIL single_idle got busy=%b done=%b exp 0/0000", busy, done); end
  endtask

  // Zero delay; abort held in the IDLE accept cycle and in the DONE cycle.
  task automatic test_zero();
    set_count(2, 0); req_valid = 4'b0100; abort = 1'b1; #1;
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL zero_ready got=%b exp=0100", req_ready); end
    tick(); abort = 1'b0; req_valid = '0;
    checks++; if (busy !== 1'b1 || active_id !== 2'd2 || remaining !== 8'd0 || done !== 4'b0) begin
      failures++; $display("FAIL zero_run busy=%b id=%0d rem=%0d done=%b exp 1/2/0/0000", busy, active_id, remaining, done);
    end
    tick(); abort = 1'b1; #1;
    checks++; if (done !== 4'b0100 || busy !== 1'b1) begin failures++; $display("FAIL zero_done got done=%b busy=%b exp 0100/1", done, busy); end
    tick(); abort = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 4'b0) begin failures++; $display("FAIL zero_idle got busy=%b done=%b exp 0/0000", busy, done); end
  endtask

  task automatic test_round_robin();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    for (int i = 0; i < NR; i++) set_count(i, 1);
    req_valid = 4'hF;
    for (int g = 0; g < 5; g++) begin
      #1;
      checks++; if (req_ready !== 4'(1 << (g % NR))) begin failures++; $display("FAIL rr_ready g=%0d got=%b exp=%b", g, req_ready, 4'(1 << (g % NR))); end
      tick();
      if (g == 4) req_valid = '0;
      checks++; if (active_id !== 2'(g % NR) || busy !== 1'b1) begin failures++; $display("FAIL rr_id g=%0d got=%0d busy=%b exp=%0d/1", g, active_id, busy, g % NR); end
      tick(); tick();
      checks++; if (done !== 4'(1 << (g % NR))) begin failures++; $display("FAIL rr_done g=%0d got=%b exp=%b", g, done, 4'(1 << (g % NR))); end
      tick();
    end
  endtask

  task automatic test_contention();
    set_count(2, 0); req_valid = 4'b0100; #1;
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL ct_pre got=%b exp=0100", req_ready); end
    tick(); req_valid = '0; tick(); tick();
    for (int i = 0; i < NR; i++) set_count(i, 0);
    req_valid = 4'b1011; #1;
    checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL ct_wrap got=%b exp=1000", req_ready); end
    tick(); req_valid = 4'b0001;
    checks++; if (active_id !== 2'd3 || done !== 4'b0) begin failures++; $display("FAIL ct_id3 got id=%0d done=%b exp 3/0000", active_id, done); end
    tick();
    checks++; if (done !== 4'b1000) begin failures++; $display("FAIL ct_done3 got=%b exp=1000", done); end
    tick(); #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL ct_next got=%b exp=0001", req_ready); end
    tick(); req_valid = '0;
    checks++; if (active_id !== 2'd0) begin failures++; $display("FAIL ct_id0 got=%0d exp=0", active_id); end
    tick();
    checks++; if (done !== 4'b0001) begin failures++; $display("FAIL ct_done0 got=%b exp=0001", done); end
    tick();
    checks++; if (busy !== 1'b0 || done !== 4'b0) begin failures++; $display("FAIL ct_idle got busy=%b done=%b exp 0/0000", busy, done); end
  endtask

  task automatic test_abort();
    set_count(1, 200); req_valid = 4'b0010; #1;
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL ab_ready got=%b exp=0010", req_ready); end
    tick(); req_valid = '0;
    checks++; if (remaining !== 8'd200) begin failures++; $display("FAIL ab_rem0 got=%0d exp=200", remaining); end
    for (int k = 1; k < 50; k++) begin
      if (k == 10) req_valid = 4'b1101;
      checks++; if (done !== 4'b0 || req_ready !== 4'b0) begin failures++; $display("FAIL ab_run k=%0d done=%b ready=%b exp 0000/0000", k, done, req_ready); end
      tick();
    end
    checks++; if (remaining !== 8'd151) begin failures++; $display("FAIL ab_rem50 got=%0d exp=151", remaining); end
    abort = 1'b1;
    tick(); abort = 1'b0; #1;
    checks++; if (busy !== 1'b0 || remaining !== 8'd0 || done !== 4'b0) begin
      failures++; $display("FAIL ab_idle busy=%b rem=%0d done=%b exp 0/0/0000", busy, remaining, done);
    end
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL ab_pending got=%b exp=0100", req_ready); end
    tick(); req_valid = '0;
    checks++; if (active_id !== 2'd2) begin failures++; $display("FAIL ab_id got=%0d exp=2", active_id); end
    tick();
    checks++; if (done !== 4'b0100) begin failures++; $display("FAIL ab_done got=%b exp=0100", done); end
    tick();
  endtask

  task automatic test_reset_mid();
    set_count(1, 12); req_valid = 4'b0010; #1;
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL rm_ready got=%b exp=0010", req_ready); end
    tick(); req_valid = '0;
    tick(); tick(); tick(); tick();
    reset = 1'b1;
    tick(); reset = 1'b0;
    checks++; if (busy !== 1'b0 || remaining !== 8'd0 || active_id !== 2'd0 || done !== 4'b0) begin
      failures++; $display("FAIL rm_vals busy=%b rem=%0d id=%0d done=%b exp 0/0/0/0000", busy, remaining, active_id, done);
    end
    for (int k = 0; k < 20; k++) begin
      checks++; if (done !== 4'b0 || busy !== 1'b0) begin failures++; $display("FAIL rm_quiet k=%0d done=%b busy=%b exp 0000/0", k, done, busy); end
      tick();
    end
    req_valid = 4'hF; #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL rm_ptr got=%b exp=0001", req_ready); end
    req_valid = '0; #1;
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL rm_withdraw got=%b exp=0000", req_ready); end
    tick();
  endtask

  task automatic test_back_to_back();
    set_count(2, 2); req_valid = 4'b0100; #1;
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL b2b_ready1 got=%b exp=0100", req_ready); end
    tick(); tick(); tick(); tick();
    checks++; if (done !== 4'b0100 || req_ready !== 4'b0) begin failures++; $display("FAIL b2b_done1 done=%b ready=%b exp 0100/0000", done, req_ready); end
    tick(); #1;
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL b2b_ready2 got=%b exp=0100", req_ready); end
    tick(); req_valid = '0;
    tick(); tick(); tick();
    checks++; if (done !== 4'b0100) begin failures++; $display("FAIL b2b_done2 got=%b exp=0100", done); end
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%b exp=0", busy); end
  endtask

  task automatic test_max();
    set_count(0, 255); req_valid = 4'b0001; #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL max_ready got=%b exp=0001", req_ready); end
    tick(); req_valid = '0;
    for (int k = 1; k < 256; k++) begin
      checks++; if (done !== 4'b0 || busy !== 1'b1 || remaining !== CW'(256-k)) begin
        failures++; $display("FAIL max_run k=%0d done=%b busy=%b rem=%0d exp 0000/1/%0d", k, done, busy, remaining, 256-k);
      end
      tick();
    end
    checks++; if (remaining !== 8'd0 || done !== 4'b0) begin failures++; $display("FAIL max_zero rem=%0d done=%b exp 0/0000", remaining, done); end
    tick();
    checks++; if (done !== 4'b0001) begin failures++; $display("FAIL max_done got=%b exp=0001", done); end
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL max_idle got=%b exp=0", busy); end
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_count = '0; abort = 1'b0;
    test_reset();
    test_single();
    test_zero();
    test_round_robin();
    test_contention();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_max();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/timer_slot_arbiter.md
Name: timer_slot_arbiter

Overview:
- Shares one cycle-delay counter among NUM_REQ requesters.
- Each requester posts a delay count; the block grants the counter round-robin, runs the delay, and pulses that requester's done line.
- Replaces per-client static timers in the core where only one delay is outstanding at a time (multi-cycle functional units, bus wait states).

Parameters:
NUM_REQ, 4, number of requesters (2..8)
CNT_WIDTH, 8, width of each requested delay count
ID_WIDTH, 2, width of active_id; must be ≥ clog2(NUM_REQ)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous reset, active-high
req_valid  input  NUM_REQ  per-requester delay request
req_count  input  NUM_REQ*CNT_WIDTH  delay per requester; requester i uses bits [i*CNT_WIDTH +: CNT_WIDTH]
req_ready  output  NUM_REQ  one-hot acceptance, combinational
abort  input  1  cancel the running delay
done  output  NUM_REQ  one-cycle completion pulse for the owning requester
busy  output  1  counter owned, from accept+1 through the done/abort cycle
active_id  output  ID_WIDTH  index of the current owner; valid while busy
remaining  output  CNT_WIDTH  live counter value; 0 when idle

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset values: state IDLE, done=0, busy=0, active_id=0, remaining=0, rr_ptr=0. req_ready=0 while reset is high.
- States: IDLE, RUN, DONE.
- IDLE:
  - Arbitrate among req_valid starting at rr_ptr, ascending with wrap.
  - req_ready[w]=1 for the winner w only; it is combinational from req_valid and registered state.
  - The acceptance edge (cycle A) latches req_count[w] into the counter and w into active_id, sets rr_ptr=(w+1) mod NUM_REQ, and enters RUN.
- RUN:
  - If counter==0, go to DONE; otherwise decrement by 1.
  - Result: for delay N, done[w] is high exactly in cycle A+N+2.
  - Back-to-back requests from the same requester therefore complete N+3 cycles apart.
- DONE:
  - done[active_id]=1 for one cycle, all other done bits 0.
  - Next state IDLE; the earliest next acceptance is cycle A+N+3.
- Requester contract: hold req_valid and req_count stable until req_ready. Dropping req_valid before acceptance withdraws the request with no side effects.
- req_ready is 0 outside IDLE. Requests raised during RUN or DONE wait and are arbitrated in the next IDLE cycle.
- abort:
  - High in RUN → IDLE next cycle, no done pulse, remaining=0, rr_ptr unchanged from acceptance.
  - Ignored in IDLE.
  - Ignored in DONE; the pulse still fires.
- Counter never wraps below 0. N=2^CNT_WIDTH−1 is legal (done at A+2^CNT_WIDTH+1).
- A reset asserted mid-RUN or mid-DONE suppresses any pending done pulse; the block is IDLE the following cycle.
- Requester indices ≥ NUM_REQ do not exist. active_id upper bits are 0.

Test Plan:
- Single request: req_valid[0]=1, count=7, accepted at cycle 10 → busy 11..19, remaining 7..0, done[0] only at cycle 19, IDLE at 20.
- Zero delay: req_valid[2]=1, count=0, accepted at cycle A → done[2] at A+2, busy A+1..A+2, active_id=2.
- Round-robin: all four req_valid held with count=1 from reset → grant order 0,1,2,3,0, accepts spaced 4 cycles apart, exactly one req_ready bit high per acceptance.
- Contention after wrap: rr_ptr=3 with req_valid=4'b1001 → requester 3 wins; next grant to 0. Requester 1 dropping req_valid before grant → never accepted, no done[1].
- Abort: count=200 accepted at A, abort=1 at A+50 → IDLE at A+51, no done pulse, remaining=0. A pending request is accepted at A+51.
- Reset mid-run: count=12 accepted, reset high for one cycle at A+5 → all outputs at reset values next cycle, no done pulse ever for that request, rr_ptr=0.
